// File: rtl/fwd_sel_ctrl.sv
// fwd_sel_ctrl: operand-forwarding controller for the KGP-RISC 5-stage pipeline.
// Tracks in-flight destinations in shadow EX/MEM records, drives registered
// EX-stage operand selects, flags load-use stalls and counts stall cycles.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   id_valid          real instruction present in ID
//   id_rs, id_rt      source registers of the ID instruction
//   id_uses_rt        ID instruction reads rt
//   id_rd             destination register of the ID instruction
//   id_reg_write      ID instruction writes id_rd
//   id_mem_read       ID instruction is a load
//   flush             squash the ID instruction (branch taken)
//   ex_sel_a/b        operand selects for the instruction in EX
//                     (00 regfile, 01 EX/MEM ALU, 10 MEM/WB)
//   id_stall          combinational load-use stall request
//   stall_count       saturating count of stall cycles
module fwd_sel_ctrl #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              flush,
  output logic [1:0]        ex_sel_a,
  output logic [1:0]        ex_sel_b,
  output logic              id_stall,
  output logic [CNT_W-1:0]  stall_count
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EXM = 2'b01;
  localparam logic [1:0] SEL_MWB = 2'b10;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
  } rec_t;

  // The register file is write-through, so a WB-stage producer never needs
  // forwarding; only the EX and MEM records influence any output.
  rec_t ex_q;
  rec_t mem_q;

  logic       ex_prod;
  logic       mem_prod;
  logic       bubble;
  logic [1:0] sel_a_c;
  logic [1:0] sel_b_c;
  rec_t       id_rec;

  // Producing records: valid, writing, and not targeting the zero register
  assign ex_prod  = ex_q.valid  & ex_q.reg_write  & (ex_q.rd  != '0);
  assign mem_prod = mem_q.valid & mem_q.reg_write & (mem_q.rd != '0);

  // Load-use hazard; a flush squashes the consumer so it never stalls
  assign id_stall = id_valid & ~flush & ex_prod & ex_q.mem_read &
                    ((ex_q.rd == id_rs) | (id_uses_rt & (ex_q.rd == id_rt)));

  assign bubble = ~id_valid | flush | id_stall;

  // Select evaluation in ID; youngest usable producer wins, a load in EX has no data yet
  always_comb begin
    sel_a_c = SEL_RF;
    sel_b_c = SEL_RF;
    if (id_rs != '0) begin
      if (ex_prod && !ex_q.mem_read && (ex_q.rd == id_rs)) begin
        sel_a_c = SEL_EXM;
      end else if (mem_prod && (mem_q.rd == id_rs)) begin
        sel_a_c = SEL_MWB;
      end
    end
    if (id_uses_rt && (id_rt != '0)) begin
      if (ex_prod && !ex_q.mem_read && (ex_q.rd == id_rt)) begin
        sel_b_c = SEL_EXM;
      end else if (mem_prod && (mem_q.rd == id_rt)) begin
        sel_b_c = SEL_MWB;
      end
    end
  end

  // Record entering EX; only the valid bit distinguishes a bubble
  always_comb begin
    id_rec           = '0;
    id_rec.valid     = ~bubble;
    id_rec.rd        = id_rd;
    id_rec.reg_write = id_reg_write;
    id_rec.mem_read  = id_mem_read;
  end

  // Shadow pipeline shift and registered selects
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_q     <= '0;
      mem_q    <= '0;
      ex_sel_a <= SEL_RF;
      ex_sel_b <= SEL_RF;
    end else begin
      mem_q    <= ex_q;
      ex_q     <= id_rec;
      ex_sel_a <= bubble ? SEL_RF : sel_a_c;
      ex_sel_b <= bubble ? SEL_RF : sel_b_c;
    end
  end

  // Saturating stall counter, bumped on the edge that inserts the bubble
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count <= '0;
    end else if (id_stall && (stall_count != '1)) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fwd_sel_ctrl.sv
// Self-checking bench for fwd_sel_ctrl: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a
// behavioural model of in-flight producers.
module tb_fwd_sel_ctrl;

  localparam int unsigned REG_AW  = 5;
  localparam int unsigned CNT_W   = 6;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              id_valid = 1'b0;
  logic [REG_AW-1:0] id_rs = '0;
  logic [REG_AW-1:0] id_rt = '0;
  logic              id_uses_rt = 1'b0;
  logic [REG_AW-1:0] id_rd = '0;
  logic              id_reg_write = 1'b0;
  logic              id_mem_read = 1'b0;
  logic              flush = 1'b0;
  logic [1:0]        ex_sel_a;
  logic [1:0]        ex_sel_b;
  logic              id_stall;
  logic [CNT_W-1:0]  stall_count;

  int n_tests = 0;
  int n_fail  = 0;

  fwd_sel_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .flush        (flush),
    .ex_sel_a     (ex_sel_a),
    .ex_sel_b     (ex_sel_b),
    .id_stall     (id_stall),
    .stall_count  (stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Instructions in flight by age: index 0 = one stage ahead of ID (EX), 1 = MEM.
  logic             m_v  [2];
  logic [REG_AW-1:0] m_rd [2];
  logic             m_rw [2];
  logic             m_ld [2];
  logic [1:0]       exp_a;
  logic [1:0]       exp_b;
  int               m_nstall;

  function automatic logic m_writes(input int k);
    return m_v[k] && m_rw[k] && (m_rd[k] != 0);
  endfunction

  // Where source s comes from: nearest older writer that already has its data
  function automatic logic [1:0] m_src(input logic [REG_AW-1:0] s);
    if (s == 0) return 2'b00;
    for (int k = 0; k < 2; k++) begin
      if (m_writes(k) && m_rd[k] == s) begin
        if (k == 0 && m_ld[0]) continue;
        return (k == 0) ? 2'b01 : 2'b10;
      end
    end
    return 2'b00;
  endfunction

  function automatic logic m_stall();
    if (!id_valid || flush) return 1'b0;
    if (!(m_writes(0) && m_ld[0])) return 1'b0;
    return (m_rd[0] == id_rs) || (id_uses_rt && m_rd[0] == id_rt);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_v[0]   <= 1'b0;
      m_v[1]   <= 1'b0;
      exp_a    <= 2'b00;
      exp_b    <= 2'b00;
      m_nstall <= 0;
    end else begin
      m_v[1]  <= m_v[0];
      m_rd[1] <= m_rd[0];
      m_rw[1] <= m_rw[0];
      m_ld[1] <= m_ld[0];
      m_v[0]  <= id_valid && !flush && !m_stall();
      m_rd[0] <= id_rd;
      m_rw[0] <= id_reg_write;
      m_ld[0] <= id_mem_read;
      exp_a   <= (id_valid && !flush && !m_stall()) ? m_src(id_rs) : 2'b00;
      exp_b   <= (id_valid && !flush && !m_stall() && id_uses_rt) ? m_src(id_rt) : 2'b00;
      if (m_stall()) m_nstall <= m_nstall + 1;
    end
  end

  // Per-cycle compare against the model, away from the rising edge
  always @(negedge clk) begin
    chk("cyc_id_stall", 32'(id_stall), 32'(m_stall()));
    chk("cyc_ex_sel_a", 32'(ex_sel_a), 32'(exp_a));
    chk("cyc_ex_sel_b", 32'(ex_sel_b), 32'(exp_b));
    chk("cyc_stall_count", 32'(stall_count),
        32'((m_nstall > CNT_MAX) ? CNT_MAX : m_nstall));
  end

  // ---------------- stimulus ----------------
  task automatic issue(input int v, input int rs, input int rt, input int ut,
                       input int rd, input int rw, input int ld, input int fl);
    @(posedge clk);
    #1;
    id_valid     = 1'(v);
    id_rs        = REG_AW'(rs);
    id_rt        = REG_AW'(rt);
    id_uses_rt   = 1'(ut);
    id_rd        = REG_AW'(rd);
    id_reg_write = 1'(rw);
    id_mem_read  = 1'(ld);
    flush        = 1'(fl);
    #1;
  endtask

  task automatic nop();
    issue(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_sel_a", 32'(ex_sel_a), 32'd0);
    chk("reset_sel_b", 32'(ex_sel_b), 32'd0);
    chk("reset_stall", 32'(id_stall), 32'd0);
    chk("reset_count", 32'(stall_count), 32'd0);
    @(negedge clk) rst = 1'b1;

    // back-to-back ALU dependency
    issue(1, 1, 2, 1, 3, 1, 0, 0);
    issue(1, 3, 4, 1, 6, 1, 0, 0);
    chk("b2b_no_stall", 32'(id_stall), 32'd0);
    nop();
    chk("b2b_sel_a", 32'(ex_sel_a), 32'd1);
    nop(); nop();

    // distance two, then priority of the younger producer
    issue(1, 1, 0, 0, 5, 1, 0, 0);
    issue(1, 2, 0, 0, 9, 1, 0, 0);
    issue(1, 5, 0, 0, 10, 1, 0, 0);
    nop();
    chk("dist2_sel_a", 32'(ex_sel_a), 32'd2);
    nop(); nop();
    issue(1, 1, 0, 0, 5, 1, 0, 0);
    issue(1, 2, 0, 0, 5, 1, 0, 0);
    issue(1, 5, 0, 0, 10, 1, 0, 0);
    nop();
    chk("prio_sel_a", 32'(ex_sel_a), 32'd1);
    nop(); nop();

    // load-use on rt
    issue(1, 1, 0, 0, 7, 1, 1, 0);
    issue(1, 2, 7, 1, 11, 1, 0, 0);
    chk("lu_stall", 32'(id_stall), 32'd1);
    issue(1, 2, 7, 1, 11, 1, 0, 0);
    chk("lu_stall_once", 32'(id_stall), 32'd0);
    chk("lu_bubble_a", 32'(ex_sel_a), 32'd0);
    chk("lu_bubble_b", 32'(ex_sel_b), 32'd0);
    nop();
    chk("lu_sel_b", 32'(ex_sel_b), 32'd2);
    chk("lu_count", 32'(stall_count), 32'd1);
    nop(); nop();
    // same load but rt unused
    issue(1, 1, 0, 0, 7, 1, 1, 0);
    issue(1, 2, 7, 0, 11, 1, 0, 0);
    chk("imm_no_stall", 32'(id_stall), 32'd0);
    nop();
    chk("imm_sel_b", 32'(ex_sel_b), 32'd0);
    nop(); nop();

    // register zero never forwards
    issue(1, 1, 0, 0, 0, 1, 0, 0);
    issue(1, 0, 0, 0, 12, 1, 0, 0);
    nop();
    chk("r0_sel_a", 32'(ex_sel_a), 32'd0);
    nop(); nop();

    // flush beats a load-use hazard
    issue(1, 1, 0, 0, 8, 1, 1, 0);
    issue(1, 8, 0, 0, 13, 1, 0, 1);
    chk("flush_stall", 32'(id_stall), 32'd0);
    nop();
    chk("flush_bubble", 32'(ex_sel_a), 32'd0);
    chk("flush_count", 32'(stall_count), 32'd1);
    nop(); nop();

    // async reset with a pending load in EX and a stalled consumer in ID
    issue(1, 1, 0, 0, 8, 1, 0, 0);
    issue(1, 8, 0, 0, 7, 1, 1, 0);
    issue(1, 7, 0, 0, 14, 1, 0, 0);
    chk("pre_rst_sel_a", 32'(ex_sel_a), 32'd1);
    chk("pre_rst_stall", 32'(id_stall), 32'd1);
    rst = 1'b0;
    #1;
    chk("arst_sel_a", 32'(ex_sel_a), 32'd0);
    chk("arst_sel_b", 32'(ex_sel_b), 32'd0);
    chk("arst_stall", 32'(id_stall), 32'd0);
    chk("arst_count", 32'(stall_count), 32'd0);
    @(negedge clk) rst = 1'b1;
    nop(); nop();

    // randomized traffic over a small register set to provoke hits
    repeat (1500) begin
      issue(($urandom_range(0, 7) != 0) ? 1 : 0,
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
            $urandom_range(0, 3), $urandom_range(0, 1),
            ($urandom_range(0, 2) == 0) ? 1 : 0,
            ($urandom_range(0, 7) == 0) ? 1 : 0);
    end
    nop(); nop();
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;

    // chain of dependent loads: 2^CNT_W+3 stalls saturate the counter
    issue(1, 0, 0, 0, 7, 1, 1, 0);
    repeat (CNT_MAX + 4) begin
      issue(1, 7, 0, 0, 7, 1, 1, 0);
      issue(1, 7, 0, 0, 7, 1, 1, 0);
    end
    nop();
    chk("sat_count", 32'(stall_count), 32'(CNT_MAX));
    nop();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
